// File: rtl/cont_mon_pkg.sv
// cont_mon_pkg
//   Shared types and default constants for the bounce-counter monitor.
//   state_t : monitor FSM states (IDLE, SYNC, UP, DOWN, ERROR)
//   CNT_W   : default width of the monitored count
//   CNT_MAX : default peak value of the monitored count
//   CYC_W   : default width of the round-trip counter
package cont_mon_pkg;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;
   localparam int CYC_W   = 8;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      UP,
      DOWN,
      ERROR
   } state_t;

endpackage

// File: rtl/cont_monitor_cycle_sat_cnt.sv
// cycle_sat_cnt
//   Saturating up-counter of completed round trips.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset, clears count
//   inc   : increment request for this edge
//   count : current count, sticks at all-ones
module cycle_sat_cnt #(
   parameter int CYC_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CYC_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {CYC_W{1'b1}})) begin
         count <= count + CYC_W'(1);
      end
   end

endmodule

// File: rtl/cont_monitor.sv
// cont_monitor
//   Checks that a sampled count follows a strict up/down bounce between 0
//   and the all-ones peak, flags any deviation with a sticky error, pulses at
//   the peak and trough, and counts completed round trips (saturating).
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   en           : sample enable for cont_in
//   cont_in      : count from the upstream bounce counter
//   err_clr      : clears a latched error (only acts in ERROR)
//   dir_out      : tracked direction, 0 = up, 1 = down
//   peak_pulse   : one-cycle pulse when an up step lands on the peak
//   trough_pulse : one-cycle pulse when a down step lands on 0
//   cycles       : completed round trips, saturating
//   err          : sticky sequence-error flag
module cont_monitor #(
   parameter int CNT_W = cont_mon_pkg::CNT_W,
   parameter int CYC_W = cont_mon_pkg::CYC_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [CNT_W-1:0] cont_in,
   input  logic             err_clr,
   output logic             dir_out,
   output logic             peak_pulse,
   output logic             trough_pulse,
   output logic [CYC_W-1:0] cycles,
   output logic             err
);

   import cont_mon_pkg::*;

   localparam logic [CNT_W-1:0] PEAK = {CNT_W{1'b1}};

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] prev_reg, prev_next;
   logic             dir_next, peak_next, trough_next, err_next;
   logic             inc;
   logic [CNT_W-1:0] prev_inc, prev_dec;
   logic             step_up, step_dn;

   // Neighbours of prev; the guards on prev reject the wrap-around
   // transitions 15->0 and 0->15.
   assign prev_inc = prev_reg + CNT_W'(1);
   assign prev_dec = prev_reg - CNT_W'(1);
   assign step_up  = (cont_in == prev_inc) && (prev_reg != PEAK);
   assign step_dn  = (cont_in == prev_dec) && (prev_reg != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         prev_reg     <= '0;
         dir_out      <= 1'b0;
         peak_pulse   <= 1'b0;
         trough_pulse <= 1'b0;
         err          <= 1'b0;
      end else begin
         state_reg    <= state_next;
         prev_reg     <= prev_next;
         dir_out      <= dir_next;
         peak_pulse   <= peak_next;
         trough_pulse <= trough_next;
         err          <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      prev_next   = prev_reg;
      dir_next    = dir_out;
      peak_next   = 1'b0;
      trough_next = 1'b0;
      err_next    = err;
      inc         = 1'b0;
      case (state_reg)
         ERROR: begin
            // Only err_clr leaves ERROR; en and cont_in are ignored here.
            if (err_clr) begin
               state_next = IDLE;
               err_next   = 1'b0;
               dir_next   = 1'b0;
            end
         end
         IDLE: begin
            if (en) begin
               prev_next  = cont_in;
               state_next = SYNC;
               dir_next   = 1'b0;
            end
         end
         default: begin
            // SYNC accepts either direction; UP and DOWN only their own.
            if (en) begin
               if (step_up && (state_reg != DOWN)) begin
                  prev_next = cont_in;
                  if (cont_in == PEAK) begin
                     peak_next  = 1'b1;
                     state_next = DOWN;
                     dir_next   = 1'b1;
                  end else begin
                     state_next = UP;
                     dir_next   = 1'b0;
                  end
               end else if (step_dn && (state_reg != UP)) begin
                  prev_next = cont_in;
                  if (cont_in == '0) begin
                     trough_next = 1'b1;
                     inc         = 1'b1;
                     state_next  = UP;
                     dir_next    = 1'b0;
                  end else begin
                     state_next = DOWN;
                     dir_next   = 1'b1;
                  end
               end else begin
                  // dir_out keeps its last value while in ERROR.
                  state_next = ERROR;
                  err_next   = 1'b1;
               end
            end
         end
      endcase
   end

   cycle_sat_cnt #(
      .CYC_W(CYC_W)
   ) u_cycle_sat_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc),
      .count (cycles)
   );

endmodule

// File: tb/tb_cont_monitor.sv
// tb_cont_monitor
//   Directed stimulus for cont_monitor with a rule-level reference model
//   compared on every falling edge, plus hand-computed literal expectations.
module tb_cont_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       err_clr = 1'b0;
   logic [3:0] cont_in = 4'd0;
   logic       dir_out, peak_pulse, trough_pulse, err;
   logic [7:0] cycles;

   int checks = 0;
   int failures = 0;
   int peaks = 0;
   int troughs = 0;

   // Model: mode 0 idle, 1 sync, 2 rising, 3 falling, 4 error.
   int m_mode = 0, m_prev = 0, m_dir = 0, m_peak = 0, m_trough = 0;
   int m_cycles = 0, m_err = 0;

   cont_monitor dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .cont_in      (cont_in),
      .err_clr      (err_clr),
      .dir_out      (dir_out),
      .peak_pulse   (peak_pulse),
      .trough_pulse (trough_pulse),
      .cycles       (cycles),
      .err          (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      int n_mode, n_prev, n_dir, n_peak, n_trough, n_cycles, n_err, v, d;
      if (reset) begin
         m_mode <= 0; m_prev <= 0; m_dir <= 0; m_peak <= 0;
         m_trough <= 0; m_cycles <= 0; m_err <= 0;
      end else begin
         n_mode = m_mode; n_prev = m_prev; n_dir = m_dir;
         n_peak = 0; n_trough = 0; n_cycles = m_cycles; n_err = m_err;
         v = int'(cont_in);
         d = v - m_prev;
         if (m_mode == 4) begin
            if (err_clr) begin
               n_mode = 0; n_err = 0; n_dir = 0;
            end
         end else if (en) begin
            if (m_mode == 0) begin
               n_prev = v; n_mode = 1; n_dir = 0;
            end else if (d == 1 && m_mode != 3) begin
               n_prev = v;
               if (v == 15) begin
                  n_peak = 1; n_mode = 3; n_dir = 1;
               end else begin
                  n_mode = 2; n_dir = 0;
               end
            end else if (d == -1 && m_mode != 2) begin
               n_prev = v;
               if (v == 0) begin
                  n_trough = 1; n_mode = 2; n_dir = 0;
                  if (n_cycles < 255) n_cycles = n_cycles + 1;
               end else begin
                  n_mode = 3; n_dir = 1;
               end
            end else begin
               n_mode = 4; n_err = 1;
            end
         end
         m_mode <= n_mode; m_prev <= n_prev; m_dir <= n_dir; m_peak <= n_peak;
         m_trough <= n_trough; m_cycles <= n_cycles; m_err <= n_err;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         chk("dir_out", int'(dir_out), m_dir);
         chk("peak_pulse", int'(peak_pulse), m_peak);
         chk("trough_pulse", int'(trough_pulse), m_trough);
         chk("cycles", int'(cycles), m_cycles);
         chk("err", int'(err), m_err);
         peaks   <= peaks + int'(peak_pulse);
         troughs <= troughs + int'(trough_pulse);
      end
   end

   // One sampling edge per call; en/err_clr drop right after the edge.
   task automatic step(input logic e, input int v, input logic c);
      @(negedge clk);
      en = e; cont_in = 4'(v); err_clr = c;
      $display("step en=%0d cont_in=%0d err_clr=%0d", e, v, c);
      @(posedge clk);
      #1;
      en = 1'b0; err_clr = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; en = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      #1;
      peaks = 0; troughs = 0;
      reset = 1'b0;
   endtask

   task automatic trip();
      for (int v = 1; v <= 15; v++) step(1'b1, v, 1'b0);
      for (int v = 14; v >= 0; v--) step(1'b1, v, 1'b0);
   endtask

   initial begin
      // Reset state
      #1;
      chk("reset_dir", int'(dir_out), 0);
      chk("reset_cycles", int'(cycles), 0);
      chk("reset_err", int'(err), 0);
      do_reset();

      // Full bounce 0..15..0 then 1
      for (int v = 0; v <= 15; v++) step(1'b1, v, 1'b0);
      settle();
      chk("peak_after_15", int'(peak_pulse), 1);
      chk("dir_at_peak", int'(dir_out), 1);
      for (int v = 14; v >= 0; v--) step(1'b1, v, 1'b0);
      step(1'b1, 1, 1'b0);
      settle();
      chk("bounce_peaks", peaks, 1);
      chk("bounce_troughs", troughs, 1);
      chk("bounce_cycles", int'(cycles), 1);
      chk("bounce_err", int'(err), 0);
      chk("bounce_dir", int'(dir_out), 0);

      // Jump 5->7 while rising, then clear
      for (int v = 2; v <= 5; v++) step(1'b1, v, 1'b0);
      step(1'b1, 7, 1'b0);
      settle();
      chk("jump_err", int'(err), 1);
      chk("jump_peak", int'(peak_pulse), 0);
      chk("jump_trough", int'(trough_pulse), 0);
      step(1'b1, 8, 1'b0);
      step(1'b1, 9, 1'b0);
      settle();
      chk("err_sticky", int'(err), 1);
      step(1'b0, 9, 1'b1);
      settle();
      chk("clr_err", int'(err), 0);
      chk("clr_cycles", int'(cycles), 1);
      step(1'b1, 9, 1'b0);
      step(1'b1, 10, 1'b0);
      settle();
      chk("resync_err", int'(err), 0);

      // Start at 15 then 14
      do_reset();
      step(1'b1, 15, 1'b0);
      step(1'b1, 14, 1'b0);
      settle();
      chk("sync_down_dir", int'(dir_out), 1);
      chk("sync_down_peaks", peaks, 0);
      for (int v = 13; v >= 0; v--) step(1'b1, v, 1'b0);
      settle();
      chk("sync_down_troughs", troughs, 1);
      chk("sync_down_cycles", int'(cycles), 1);

      // en held low mid-ascent
      do_reset();
      for (int v = 0; v <= 3; v++) step(1'b1, v, 1'b0);
      step(1'b0, 9, 1'b0);
      step(1'b0, 0, 1'b0);
      step(1'b0, 14, 1'b0);
      step(1'b1, 4, 1'b0);
      step(1'b1, 5, 1'b0);
      settle();
      chk("en_gap_err", int'(err), 0);
      chk("en_gap_dir", int'(dir_out), 0);

      // Wrap attempts are errors
      do_reset();
      step(1'b1, 14, 1'b0);
      step(1'b1, 15, 1'b0);
      step(1'b1, 0, 1'b0);
      settle();
      chk("wrap_err", int'(err), 1);
      chk("wrap_dir_hold", int'(dir_out), 1);

      // Asynchronous reset in DOWN with cycles=4
      do_reset();
      step(1'b1, 0, 1'b0);
      for (int t = 0; t < 4; t++) trip();
      for (int v = 1; v <= 15; v++) step(1'b1, v, 1'b0);
      step(1'b1, 14, 1'b0);
      step(1'b1, 13, 1'b0);
      settle();
      chk("pre_reset_cycles", int'(cycles), 4);
      chk("pre_reset_dir", int'(dir_out), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_dir", int'(dir_out), 0);
      chk("async_cycles", int'(cycles), 0);
      chk("async_err", int'(err), 0);
      chk("async_pulses", int'(peak_pulse) + int'(trough_pulse), 0);
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 7, 1'b0);
      step(1'b1, 8, 1'b0);
      settle();
      chk("restart_err", int'(err), 0);
      chk("restart_dir", int'(dir_out), 0);

      // 300 round trips saturate at 255
      do_reset();
      step(1'b1, 0, 1'b0);
      for (int t = 0; t < 300; t++) trip();
      settle();
      chk("sat_cycles", int'(cycles), 255);
      chk("sat_troughs", troughs, 300);
      trip();
      settle();
      chk("sat_hold", int'(cycles), 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
